// File: rtl/sifreleme_hakemi_pkg.sv
// Shared opcode codes, FSM state codes and arbiter sizing for sifreleme_hakemi.
// The SIFRELEME_* opcode macros are defined here once for the whole slice.
`ifndef SIFRELEME_HMDST
`define SIFRELEME_HMDST 3'd0
`define SIFRELEME_PKG   3'd1
`define SIFRELEME_RVRS  3'd2
`define SIFRELEME_SLADD 3'd3
`define SIFRELEME_CNTZ  3'd4
`define SIFRELEME_CNTP  3'd5
`endif

package sifreleme_hakemi_pkg;

   localparam logic [1:0] SH_BOSTA   = 2'd0;
   localparam logic [1:0] SH_HESAPLA = 2'd1;
   localparam logic [1:0] SH_YANIT   = 2'd2;

   // Index width covers up to four requesters.
   localparam int IW = 2;

   localparam logic [2:0] OP_HMDST = `SIFRELEME_HMDST;
   localparam logic [2:0] OP_PKG   = `SIFRELEME_PKG;
   localparam logic [2:0] OP_RVRS  = `SIFRELEME_RVRS;
   localparam logic [2:0] OP_SLADD = `SIFRELEME_SLADD;
   localparam logic [2:0] OP_CNTZ  = `SIFRELEME_CNTZ;
   localparam logic [2:0] OP_CNTP  = `SIFRELEME_CNTP;

endpackage

// File: rtl/sifreleme_birimi.sv
// Combinational bit-manipulation unit: hamming distance, pack, reverse,
// shift-add, trailing-zero count and popcount; flags unknown opcodes.
module sifreleme_birimi
   import sifreleme_hakemi_pkg::*;
#(
   parameter int VERI_BIT = 32
) (
   input  logic [2:0]          kontrol_i,
   input  logic [VERI_BIT-1:0] deger1_i,
   input  logic [VERI_BIT-1:0] deger2_i,
   output logic [VERI_BIT-1:0] sonuc_o,
   output logic                gecersiz_o
);

   localparam int H = VERI_BIT / 2;

   function automatic logic [VERI_BIT-1:0] bir_say(
      input logic [VERI_BIT-1:0] x
   );
      logic [VERI_BIT-1:0] s;
      s = '0;
      for (int i = 0; i < VERI_BIT; i++)
         s = s + VERI_BIT'(x[i]);
      return s;
   endfunction

   function automatic logic [VERI_BIT-1:0] sifir_say(
      input logic [VERI_BIT-1:0] x
   );
      logic [VERI_BIT-1:0] s;
      s = VERI_BIT'(VERI_BIT);
      for (int i = VERI_BIT - 1; i >= 0; i--)
         if (x[i])
            s = VERI_BIT'(i);
      return s;
   endfunction

   function automatic logic [VERI_BIT-1:0] ters(
      input logic [VERI_BIT-1:0] x
   );
      logic [VERI_BIT-1:0] s;
      for (int i = 0; i < VERI_BIT; i++)
         s[i] = x[VERI_BIT-1-i];
      return s;
   endfunction

   always_comb begin
      sonuc_o    = '0;
      gecersiz_o = 1'b0;
      unique case (1'b1)
         kontrol_i == OP_HMDST:
            sonuc_o = bir_say(deger1_i ^ deger2_i);
         kontrol_i == OP_PKG:
            sonuc_o = {deger2_i[H-1:0], deger1_i[H-1:0]};
         kontrol_i == OP_RVRS:
            sonuc_o = ters(deger1_i);
         kontrol_i == OP_SLADD:
            sonuc_o = {deger1_i[VERI_BIT-2:0], 1'b0} + deger2_i;
         kontrol_i == OP_CNTZ:
            sonuc_o = sifir_say(deger1_i);
         kontrol_i == OP_CNTP:
            sonuc_o = bir_say(deger1_i);
         default:
            gecersiz_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/sifreleme_hakemi_donusumlu_hakem.sv
// Round-robin picker: first valid requester at or above the pointer,
// otherwise the lowest valid one below it.
module donusumlu_hakem
   import sifreleme_hakemi_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [IW-1:0] isaretci_i,
   input  logic [N-1:0]  gecerli_i,
   output logic [N-1:0]  izin_o,
   output logic [IW-1:0] indeks_o,
   output logic          herhangi_o
);

   logic          bulundu;
   logic [IW-1:0] secim;

   always_comb begin
      bulundu = 1'b0;
      secim   = '0;
      for (int j = 0; j < N; j++)
         if (!bulundu && gecerli_i[j] && IW'(j) >= isaretci_i) begin
            bulundu = 1'b1;
            secim   = IW'(j);
         end
      // Wrap-around pass only wins when nothing sat above the pointer.
      for (int j = 0; j < N; j++)
         if (!bulundu && gecerli_i[j]) begin
            bulundu = 1'b1;
            secim   = IW'(j);
         end
   end

   always_comb begin
      izin_o = '0;
      for (int j = 0; j < N; j++)
         izin_o[j] = bulundu && (secim == IW'(j));
   end

   assign indeks_o   = secim;
   assign herhangi_o = bulundu;

endmodule

// File: rtl/sifreleme_hakemi.sv
// Round-robin arbiter sharing one sifreleme_birimi between N requesters.
// Define SIFRELEME_SAYAC_EN to add completion and wait-cycle counters.
module sifreleme_hakemi
   import sifreleme_hakemi_pkg::*;
#(
   parameter int ISTEKCI_SAYISI = 2,
   parameter int VERI_BIT       = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [ISTEKCI_SAYISI-1:0]    istek_gecerli_i,
   output logic [ISTEKCI_SAYISI-1:0]    istek_hazir_o,
   input  logic [3*ISTEKCI_SAYISI-1:0]  istek_kontrol_i,
   input  logic [VERI_BIT*ISTEKCI_SAYISI-1:0] istek_deger1_i,
   input  logic [VERI_BIT*ISTEKCI_SAYISI-1:0] istek_deger2_i,
   output logic [ISTEKCI_SAYISI-1:0]    yanit_gecerli_o,
   input  logic [ISTEKCI_SAYISI-1:0]    yanit_hazir_i,
   output logic [VERI_BIT-1:0]          sonuc_o,
   output logic                         hata_o
`ifdef SIFRELEME_SAYAC_EN
   ,
   output logic [31:0]                  tamamlanan_o,
   output logic [31:0]                  bekleme_o
`endif
);

   localparam int N = ISTEKCI_SAYISI;

   logic [1:0]          durum;
   logic [IW-1:0]       isaretci;
   logic [IW-1:0]       secilen;
   logic [2:0]          kontrol_r;
   logic [VERI_BIT-1:0] deger1_r;
   logic [VERI_BIT-1:0] deger2_r;
   logic [VERI_BIT-1:0] sonuc_r;
   logic                hata_r;

   logic [N-1:0]        izin;
   logic [IW-1:0]       izin_indeks;
   logic                herhangi;
   logic [2:0]          sec_kontrol;
   logic [VERI_BIT-1:0] sec_deger1;
   logic [VERI_BIT-1:0] sec_deger2;
   logic [VERI_BIT-1:0] birim_sonuc;
   logic                birim_gecersiz;
   logic                el_sikisma;
   logic [IW-1:0]       sonraki_isaretci;

   donusumlu_hakem #(
      .N (N)
   ) u_hakem (
      .isaretci_i (isaretci),
      .gecerli_i  (istek_gecerli_i),
      .izin_o     (izin),
      .indeks_o   (izin_indeks),
      .herhangi_o (herhangi)
   );

   sifreleme_birimi #(
      .VERI_BIT (VERI_BIT)
   ) u_birim (
      .kontrol_i  (kontrol_r),
      .deger1_i   (deger1_r),
      .deger2_i   (deger2_r),
      .sonuc_o    (birim_sonuc),
      .gecersiz_o (birim_gecersiz)
   );

   always_comb begin
      sec_kontrol = '0;
      sec_deger1  = '0;
      sec_deger2  = '0;
      for (int i = 0; i < N; i++)
         if (izin[i]) begin
            sec_kontrol = istek_kontrol_i[3*i +: 3];
            sec_deger1  = istek_deger1_i[VERI_BIT*i +: VERI_BIT];
            sec_deger2  = istek_deger2_i[VERI_BIT*i +: VERI_BIT];
         end
   end

   always_comb begin
      yanit_gecerli_o = '0;
      for (int i = 0; i < N; i++)
         yanit_gecerli_o[i] = (durum == SH_YANIT) &&
                              (secilen == IW'(i));
   end

   assign istek_hazir_o = (durum == SH_BOSTA) ? izin : '0;
   assign el_sikisma    = |(yanit_gecerli_o & yanit_hazir_i);
   assign sonraki_isaretci = (secilen == IW'(N - 1)) ?
                             '0 : secilen + IW'(1);
   assign sonuc_o = sonuc_r;
   assign hata_o  = hata_r;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum     <= SH_BOSTA;
         isaretci  <= '0;
         secilen   <= '0;
         kontrol_r <= '0;
         deger1_r  <= '0;
         deger2_r  <= '0;
         sonuc_r   <= '0;
         hata_r    <= 1'b0;
      end else begin
         unique case (durum)
            SH_BOSTA: begin
               if (herhangi) begin
                  secilen   <= izin_indeks;
                  kontrol_r <= sec_kontrol;
                  deger1_r  <= sec_deger1;
                  deger2_r  <= sec_deger2;
                  durum     <= SH_HESAPLA;
               end
            end
            SH_HESAPLA: begin
               sonuc_r  <= birim_gecersiz ? '0 : birim_sonuc;
               hata_r   <= birim_gecersiz;
               isaretci <= sonraki_isaretci;
               durum    <= SH_YANIT;
            end
            SH_YANIT: begin
               if (el_sikisma)
                  durum <= SH_BOSTA;
            end
            default: durum <= SH_BOSTA;
         endcase
      end
   end

`ifdef SIFRELEME_SAYAC_EN
   logic [31:0] tamamlanan_r;
   logic [31:0] bekleme_r;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tamamlanan_r <= '0;
         bekleme_r    <= '0;
      end else begin
         if (el_sikisma)
            tamamlanan_r <= tamamlanan_r + 32'd1;
         if (|istek_gecerli_i && !(|istek_hazir_o))
            bekleme_r <= bekleme_r + 32'd1;
      end
   end

   assign tamamlanan_o = tamamlanan_r;
   assign bekleme_o    = bekleme_r;
`endif

endmodule
